// File: rtl/updown_seq_ctrl.sv
// updown_seq_ctrl: two requesters share one 4-bit up/down counter.
// A round-robin arbiter grants the counter to one requester, which then
// steps q one count per cycle toward its latched target. Direction is the
// shortest modulo-16 path (SHORTEST=1) or the direct, non-wrapping path
// (SHORTEST=0). Dropping the granted request mid-move abandons the move.
module updown_seq_ctrl #(
    parameter bit SHORTEST = 1'b1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [1:0] req,
    input  logic [3:0] tgt0,
    input  logic [3:0] tgt1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [3:0] q,
    output logic       up_down,
    output logic       count_en,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic       rr;
    logic [3:0] tgt_l;

    logic       pick;
    logic [3:0] tgt_sel;
    logic [3:0] q_step;
    logic       owner;
    logic       grant_now;

    // Direction for a move from cur to tgt: 1 = count down, 0 = count up.
    // Shortest mode breaks the distance-8 tie toward up.
    function automatic logic dir_down(input logic [3:0] tgt, input logic [3:0] cur);
        logic [3:0] d;
        d = tgt - cur;
        if (SHORTEST) begin
            return !((d >= 4'd1) && (d <= 4'd8));
        end else begin
            return !(tgt > cur);
        end
    endfunction

    // Arbitration choice, candidate target and next counter value.
    always_comb begin
        pick      = req[rr] ? rr : ~rr;
        tgt_sel   = pick ? tgt1 : tgt0;
        q_step    = up_down ? (q - 4'd1) : (q + 4'd1);
        owner     = gnt[1];
        grant_now = (state == IDLE) && (req != 2'b00);
    end

    // Target latch; captured only on the grant edge so later target changes are ignored.
    always_ff @(posedge clk) begin
        if (grant_now) begin
            tgt_l <= tgt_sel;
        end
    end

    // Control FSM: arbitration, counting, completion and abort handling.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            rr      <= 1'b0;
            q       <= 4'd0;
            gnt     <= 2'b00;
            up_down <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt     <= pick ? 2'b10 : 2'b01;
                        up_down <= dir_down(tgt_sel, q);
                        state   <= (tgt_sel == q) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!req[owner]) begin
                        // Requester withdrew: release without a done pulse, q held.
                        gnt   <= 2'b00;
                        rr    <= ~owner;
                        state <= IDLE;
                    end else begin
                        q <= q_step;
                        if (q_step == tgt_l) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    gnt   <= 2'b00;
                    rr    <= ~owner;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign count_en = (state == RUN);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE) ? gnt : 2'b00;

endmodule
